mux_select_scanner: RTL and testbench

//  Upstream sequencer for the 8:1 select stage. Drives the 3-bit select bus through channels 0..7.

---
 rtl/mux_select_scanner.sv | 143 ++++++++++++++
 tb/tb_mux_select_scanner.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_select_scanner.sv
// mux_select_scanner: walks the 3-bit select bus of an 8:1 mux through
// channels 0..7. It waits SETTLE_CYCLES clocks on each channel, samples mux_y,
// and assembles the eight samples into a byte. The byte is offered downstream
// with a valid/ready handshake. Supports one-shot and continuous scanning.
// Optional feature: define MUX_SCAN_PARITY_EN to add the registered
// word_parity output (^word).
module mux_select_scanner #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       continuous,
  output logic [2:0] sel,
  input  logic       mux_y,
  output logic [7:0] word,
  output logic       word_valid,
  input  logic       word_ready,
  output logic       busy,
  output logic       overrun
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic       word_parity
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // With zero settle time each channel goes straight to SAMPLE.
  localparam bit NO_SETTLE = (SETTLE_CYCLES == 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    NO_SETTLE ? '0 : CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       shift;

  assign busy = (state != IDLE);

  // State register; reset abandons any scan in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; scan entry skips SETTLE when no settle time is configured.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (NO_SETTLE) next_state = SAMPLE;
          else           next_state = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == CNT_LAST) next_state = SAMPLE;
      end
      SAMPLE: begin
        if (sel == 3'd7)    next_state = DONE;
        else if (NO_SETTLE) next_state = SAMPLE;
        else                next_state = SETTLE;
      end
      DONE: begin
        if (!continuous)    next_state = IDLE;
        else if (NO_SETTLE) next_state = SAMPLE;
        else                next_state = SETTLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Select bus, settle counter and sample shift register; sel returns to 0 only through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel   <= 3'd0;
      cnt   <= '0;
      shift <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sel <= 3'd0;
            cnt <= '0;
          end
        end
        SETTLE: begin
          cnt <= cnt + CNT_W'(1);
        end
        SAMPLE: begin
          shift[sel] <= mux_y;
          if (sel != 3'd7) begin
            sel <= sel + 3'd1;
            cnt <= '0;
          end
        end
        DONE: begin
          sel <= 3'd0;
          cnt <= '0;
        end
        default: begin
          sel <= 3'd0;
          cnt <= '0;
        end
      endcase
    end
  end

  // Output word, handshake and sticky overrun; a DONE load may coincide with a consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word        <= 8'h00;
      word_valid  <= 1'b0;
      overrun     <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      word_parity <= 1'b0;
`endif
    end else begin
      if ((state == IDLE) && start) overrun <= 1'b0;
      if (state == DONE) begin
        if (!word_valid || word_ready) begin
          word        <= shift;
          word_valid  <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
          word_parity <= ^shift;
`endif
        end else begin
          overrun <= 1'b1;
        end
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_select_scanner.sv
// tb_mux_select_scanner: drives two scanners side by side (settle time 2 and
// settle time 0) with identical stimulus. Each mux is modelled as pat[sel].
// A timeline-based reference model predicts every output after every edge.
module tb_mux_select_scanner;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       continuous;
  logic       word_ready;
  logic [7:0] pat;

  logic [2:0] sel_a, sel_b;
  logic       mux_y_a, mux_y_b;
  logic [7:0] word_a, word_b;
  logic       word_valid_a, word_valid_b;
  logic       busy_a, busy_b;
  logic       overrun_a, overrun_b;
`ifdef MUX_SCAN_PARITY_EN
  logic       word_parity_a, word_parity_b;
`endif

  int total;
  int bad;

  // Reference model state, index 0 = settle 2, index 1 = settle 0.
  int         m_settle [2];
  int         m_edge   [2];
  bit         m_busy   [2];
  logic [7:0] m_shift  [2];
  logic [7:0] m_word   [2];
  bit         m_valid  [2];
  bit         m_ovr    [2];

  assign mux_y_a = pat[sel_a];
  assign mux_y_b = pat[sel_b];

  mux_select_scanner #(.SETTLE_CYCLES(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .sel(sel_a), .mux_y(mux_y_a), .word(word_a), .word_valid(word_valid_a),
    .word_ready(word_ready), .busy(busy_a), .overrun(overrun_a)
`ifdef MUX_SCAN_PARITY_EN
    , .word_parity(word_parity_a)
`endif
  );

  mux_select_scanner #(.SETTLE_CYCLES(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .sel(sel_b), .mux_y(mux_y_b), .word(word_b), .word_valid(word_valid_b),
    .word_ready(word_ready), .busy(busy_b), .overrun(overrun_b)
`ifdef MUX_SCAN_PARITY_EN
    , .word_parity(word_parity_b)
`endif
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      m_edge[d]  = 0;
      m_busy[d]  = 1'b0;
      m_shift[d] = 8'h00;
      m_word[d]  = 8'h00;
      m_valid[d] = 1'b0;
      m_ovr[d]   = 1'b0;
    end
  endtask

  // Advance the model by one clock edge. A scan is a timeline of edges counted
  // from the accepted start: channel k is captured at edge (k+1)*(S+1) and
  // the byte is published at edge 8*(S+1)+1.
  task automatic modelEdge(input int d);
    int c, p, w;
    c = m_settle[d] + 1;
    p = 8 * c + 1;
    if (!rst_n) begin
      m_edge[d] = 0; m_busy[d] = 1'b0; m_shift[d] = 8'h00;
      m_word[d] = 8'h00; m_valid[d] = 1'b0; m_ovr[d] = 1'b0;
    end else if (!m_busy[d]) begin
      if (m_valid[d] && word_ready) m_valid[d] = 1'b0;
      if (start) begin
        m_busy[d] = 1'b1;
        m_edge[d] = 0;
        m_ovr[d]  = 1'b0;
      end
    end else begin
      m_edge[d]++;
      w = m_edge[d];
      if (w == p) begin
        if (!m_valid[d] || word_ready) begin
          m_word[d]  = m_shift[d];
          m_valid[d] = 1'b1;
        end else begin
          m_ovr[d] = 1'b1;
        end
        if (continuous) m_edge[d] = 0;
        else            m_busy[d] = 1'b0;
      end else begin
        if (m_valid[d] && word_ready) m_valid[d] = 1'b0;
        if ((w % c) == 0) m_shift[d][w / c - 1] = pat[w / c - 1];
      end
    end
  endtask

  function automatic logic [2:0] modelSel(input int d);
    int ch;
    if (!m_busy[d]) return 3'd0;
    ch = m_edge[d] / (m_settle[d] + 1);
    if (ch > 7) ch = 7;
    return 3'(ch);
  endfunction

  task automatic checkDut(input int d, input logic [2:0] s, input logic [7:0] w,
                          input logic v, input logic b, input logic o, input logic par);
    checkOutput($sformatf("d%0d_sel", d),     32'(s), 32'(modelSel(d)));
    checkOutput($sformatf("d%0d_word", d),    32'(w), 32'(m_word[d]));
    checkOutput($sformatf("d%0d_valid", d),   32'(v), 32'(m_valid[d]));
    checkOutput($sformatf("d%0d_busy", d),    32'(b), 32'(m_busy[d]));
    checkOutput($sformatf("d%0d_overrun", d), 32'(o), 32'(m_ovr[d]));
`ifdef MUX_SCAN_PARITY_EN
    checkOutput($sformatf("d%0d_parity", d),  32'(par), 32'(^m_word[d]));
`else
    if (par !== 1'b0) checkOutput($sformatf("d%0d_parity_tie", d), 32'(par), 32'd0);
`endif
  endtask

  task automatic checkAll();
    logic pa, pb;
`ifdef MUX_SCAN_PARITY_EN
    pa = word_parity_a;
    pb = word_parity_b;
`else
    pa = 1'b0;
    pb = 1'b0;
`endif
    checkDut(0, sel_a, word_a, word_valid_a, busy_a, overrun_a, pa);
    checkDut(1, sel_b, word_b, word_valid_b, busy_b, overrun_b, pb);
  endtask

  // One clock: both DUTs and the model see the same edge, outputs checked 1 unit later.
  task automatic applyStimulus();
    @(posedge clk);
    modelEdge(0);
    modelEdge(1);
    #1;
    checkAll();
  endtask

  initial begin
    int first_a, first_b, guard;
    total = 0;
    bad   = 0;
    m_settle[0] = 2;
    m_settle[1] = 0;
    modelReset();
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; word_ready = 1'b0; pat = 8'h00;

    // Reset state
    #12;
    checkAll();
    checkOutput("rst_sel", 32'(sel_a), 32'd0);
    checkOutput("rst_valid", 32'(word_valid_a), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus();

    // One-shot scan, 0xA5, ready high; a start pulse mid-scan must be ignored
    $display("[TB] one-shot scan with ignored restart");
    pat = 8'hA5; word_ready = 1'b1; start = 1'b1;
    applyStimulus();
    start = 1'b0;
    first_a = 0; first_b = 0;
    for (int i = 1; i <= 30; i++) begin
      start = (i == 10);
      applyStimulus();
      if (word_valid_a && first_a == 0) first_a = i;
      if (word_valid_b && first_b == 0) first_b = i;
      if (i == 25) begin
        checkOutput("c1_word_at_25", 32'(word_a), 32'h0000_00A5);
        checkOutput("c1_busy_at_25", 32'(busy_a), 32'd0);
        checkOutput("c1_sel_at_25", 32'(sel_a), 32'd0);
      end
      if (i == 9) checkOutput("c2_word_at_9", 32'(word_b), 32'h0000_00A5);
    end
    start = 1'b0;
    checkOutput("c1_latency", 32'(first_a), 32'd25);
    checkOutput("c2_latency", 32'(first_b), 32'd9);

    // Zero-settle scan of 0x3C
    pat = 8'h3C; start = 1'b1;
    applyStimulus();
    start = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      applyStimulus();
      if (i == 9) checkOutput("c2_word_3c", 32'(word_b), 32'h0000_003C);
    end
`ifdef MUX_SCAN_PARITY_EN
    checkOutput("c2_parity_3c", 32'(word_parity_b), 32'd0);
    pat = 8'h01; start = 1'b1;
    applyStimulus();
    start = 1'b0;
    for (int i = 1; i <= 30; i++) applyStimulus();
    checkOutput("c2_parity_01", 32'(word_parity_b), 32'd1);
`endif

    // Continuous, nobody consumes: second word dropped, overrun set
    $display("[TB] continuous scan with overrun");
    word_ready = 1'b0; continuous = 1'b1; pat = 8'hF0; start = 1'b1;
    applyStimulus();
    start = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      if (i == 26) pat = 8'h0F;
      applyStimulus();
      if (i == 25) checkOutput("c3_first_word", 32'(word_a), 32'h0000_00F0);
    end
    checkOutput("c3_word_kept", 32'(word_a), 32'h0000_00F0);
    checkOutput("c3_overrun", 32'(overrun_a), 32'd1);
    checkOutput("c3_still_busy", 32'(busy_a), 32'd1);
    continuous = 1'b0; word_ready = 1'b1;
    for (int i = 0; i < 40; i++) applyStimulus();

    // Continuous, consume exactly on the second DONE edge
    $display("[TB] continuous scan with simultaneous consume");
    word_ready = 1'b0; continuous = 1'b1; pat = 8'h5A; start = 1'b1;
    applyStimulus();
    start = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      if (i == 26) pat = 8'hC3;
      word_ready = (i == 50);
      applyStimulus();
    end
    checkOutput("c4_word", 32'(word_a), 32'h0000_00C3);
    checkOutput("c4_valid", 32'(word_valid_a), 32'd1);
    checkOutput("c4_overrun", 32'(overrun_a), 32'd0);
    continuous = 1'b0; word_ready = 1'b1;
    for (int i = 0; i < 40; i++) applyStimulus();

    // Asynchronous reset mid-scan, then a clean scan
    $display("[TB] reset mid-scan");
    pat = 8'($urandom); start = 1'b1;
    applyStimulus();
    start = 1'b0;
    guard = 0;
    while (sel_a != 3'd4 && guard < 40) begin
      applyStimulus();
      guard++;
    end
    checkOutput("c5_sel4_reached", 32'(sel_a), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("c5_sel", 32'(sel_a), 32'd0);
    checkOutput("c5_valid", 32'(word_valid_a), 32'd0);
    checkOutput("c5_busy", 32'(busy_a), 32'd0);
    checkAll();
    applyStimulus();
    rst_n = 1'b1;
    pat = 8'h81; start = 1'b1;
    applyStimulus();
    start = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      applyStimulus();
      if (i == 25) checkOutput("c5_clean_word", 32'(word_a), 32'h0000_0081);
    end

    // Randomized traffic against the model
    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      pat        = 8'($urandom);
      word_ready = 1'($urandom_range(0, 1));
      start      = ($urandom_range(0, 9) == 0);
      if ((i % 100) == 0) continuous = 1'($urandom_range(0, 1));
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
